// File: rtl/branch_resolver.sv
// Branch resolver: in-flight {pc, npc_pred} FIFO checked against execute results; mispredicts flush and redirect.
// Latency: BTB update and redirect strobes one cycle after the resolving edge; no backpressure, a push to a full queue is dropped and flagged.
module branch_resolver #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [15:0]                push_pc,
    input  logic [15:0]                push_npc_pred,
    input  logic                       resolve,
    input  logic [15:0]                resolve_npc,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       btb_we,
    output logic [15:0]                btb_pc,
    output logic [15:0]                btb_npc,
    output logic                       redirect,
    output logic [15:0]                redirect_pc,
    output logic [15:0]                mispredict_cnt,
    output logic                       err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t          state;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [15:0]     pc_mem  [DEPTH];
    logic [15:0]     npc_mem [DEPTH];

    logic            in_run;
    logic            res_ok;
    logic            mispred;
    logic            res_hit;
    logic            push_ok;
    logic            push_err;
    logic            res_err;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A push may reuse the slot freed by a same-cycle correct resolve, so full only blocks when nothing pops.
    always_comb begin
        in_run   = (state == RUN);
        res_ok   = resolve && in_run && !empty;
        mispred  = res_ok && (resolve_npc != npc_mem[head]);
        res_hit  = res_ok && !mispred;
        push_ok  = push && in_run && !mispred && (!full || res_hit);
        push_err = push && in_run && full && !res_ok;
        res_err  = resolve && !res_ok;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[tail]  <= push_pc;
            npc_mem[tail] <= push_npc_pred;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            btb_we         <= 1'b0;
            btb_pc         <= '0;
            btb_npc        <= '0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
            err            <= 1'b0;
        end else begin
            btb_we   <= mispred;
            redirect <= mispred;
            if (push_err || res_err)
                err <= 1'b1;

            case (state)
                RUN:     if (mispred) state <= RECOVER;
                default: state <= RUN;
            endcase

            if (mispred) begin
                // Everything younger than the head is wrong-path work.
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                btb_pc      <= pc_mem[head];
                btb_npc     <= resolve_npc;
                redirect_pc <= resolve_npc;
                if (mispredict_cnt != 16'hFFFF)
                    mispredict_cnt <= mispredict_cnt + 16'd1;
            end else begin
                if (push_ok)
                    tail <= tail + PW'(1);
                if (res_hit)
                    head <= head + PW'(1);
                if (push_ok && !res_hit)
                    count <= count + CW'(1);
                else if (res_hit && !push_ok)
                    count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver (DEPTH=4) with hand-computed expectations.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic [15:0] push_pc = '0;
    logic [15:0] push_npc_pred = '0;
    logic        resolve = 1'b0;
    logic [15:0] resolve_npc = '0;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        btb_we;
    logic [15:0] btb_pc;
    logic [15:0] btb_npc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mispredict_cnt;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolver #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_pc(push_pc), .push_npc_pred(push_npc_pred),
        .resolve(resolve), .resolve_npc(resolve_npc),
        .full(full), .empty(empty), .count(count),
        .btb_we(btb_we), .btb_pc(btb_pc), .btb_npc(btb_npc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mispredict_cnt(mispredict_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one cycle of stimulus, then land 1ns after the edge with inputs idle.
    task automatic cyc(input logic p, input logic [15:0] pc, input logic [15:0] npc,
                       input logic r, input logic [15:0] rn);
        push = p; push_pc = pc; push_npc_pred = npc;
        resolve = r; resolve_npc = rn;
        @(posedge clk);
        #1;
        push = 1'b0;
        resolve = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_btb_we", 32'(btb_we), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_mcnt", 32'(mispredict_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Correct prediction
        cyc(1'b1, 16'h0100, 16'h0104, 1'b0, 16'h0);
        chk("ok_count1", 32'(count), 32'd1);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0104);
        chk("ok_count0", 32'(count), 32'd0);
        chk("ok_btb_we", 32'(btb_we), 32'd0);
        chk("ok_redirect", 32'(redirect), 32'd0);
        chk("ok_mcnt", 32'(mispredict_cnt), 32'd0);

        // Misprediction flushes both entries
        cyc(1'b1, 16'h0200, 16'h0204, 1'b0, 16'h0);
        cyc(1'b1, 16'h0204, 16'h0208, 1'b0, 16'h0);
        chk("mp_count2", 32'(count), 32'd2);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0300);
        chk("mp_btb_we", 32'(btb_we), 32'd1);
        chk("mp_btb_pc", 32'(btb_pc), 32'h0200);
        chk("mp_btb_npc", 32'(btb_npc), 32'h0300);
        chk("mp_redirect", 32'(redirect), 32'd1);
        chk("mp_redirect_pc", 32'(redirect_pc), 32'h0300);
        chk("mp_count0", 32'(count), 32'd0);
        chk("mp_mcnt", 32'(mispredict_cnt), 32'd1);
        cyc(1'b1, 16'h0400, 16'h0404, 1'b0, 16'h0);
        chk("rec_btb_we_pulse", 32'(btb_we), 32'd0);
        chk("rec_redirect_pulse", 32'(redirect), 32'd0);
        chk("rec_push_dropped", 32'(count), 32'd0);
        chk("rec_err", 32'(err), 32'd0);

        // Fill, overflow, push+pop across wrap, drain in order
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'(16'h1000 + 16 * i), 16'(16'h1004 + 16 * i), 1'b0, 16'h0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        cyc(1'b1, 16'h2000, 16'h2004, 1'b0, 16'h0);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_err", 32'(err), 32'd1);
        cyc(1'b1, 16'h1040, 16'h1044, 1'b1, 16'h1004);
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_btb_we", 32'(btb_we), 32'd0);
        for (int i = 1; i < 5; i++)
            cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'(16'h1004 + 16 * i));
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_order_mcnt", 32'(mispredict_cnt), 32'd1);
        chk("drain_btb_we", 32'(btb_we), 32'd0);

        // Fresh reset, then resolve with nothing in flight
        rst = 1'b0;
        #3;
        rst = 1'b1;
        idle();
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_mcnt", 32'(mispredict_cnt), 32'd0);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0500);
        chk("empty_res_err", 32'(err), 32'd1);
        chk("empty_res_btb_we", 32'(btb_we), 32'd0);
        chk("empty_res_redirect", 32'(redirect), 32'd0);
        chk("empty_res_count", 32'(count), 32'd0);

        // Mid-cycle reset with three entries in flight
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 16'(16'h0600 + 4 * i), 16'(16'h0604 + 4 * i), 1'b0, 16'h0);
        chk("mid_count3", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_err", 32'(err), 32'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 16'h0100, 16'h0104, 1'b0, 16'h0);
        chk("post_count1", 32'(count), 32'd1);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 16'h0104);
        chk("post_count0", 32'(count), 32'd0);
        chk("post_btb_we", 32'(btb_we), 32'd0);
        chk("post_redirect", 32'(redirect), 32'd0);
        chk("post_mcnt", 32'(mispredict_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter DEPTH, default 4, in-flight prediction queue depth; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 push  input  1  fetch issues one predicted instruction this cycle.
REQ-005 push_pc  input  16  PC of the issued instruction.
REQ-006 push_npc_pred  input  16  BTB-predicted next PC for push_pc.
REQ-007 resolve  input  1  execute resolves the oldest in-flight instruction this cycle.
REQ-008 resolve_npc  input  16  actual next PC of the resolved instruction.
REQ-009 full  output  1  queue holds DEPTH entries, combinational from count.
REQ-010 empty  output  1  queue holds 0 entries, combinational from count.
REQ-011 count  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-012 btb_we  output  1  registered one-cycle BTB update strobe.
REQ-013 btb_pc  output  16  registered BTB update PC, qualified by btb_we.
REQ-014 btb_npc  output  16  registered BTB update target, qualified by btb_we.
REQ-015 redirect  output  1  registered one-cycle fetch redirect strobe.
REQ-016 redirect_pc  output  16  registered redirect target, qualified by redirect.
REQ-017 mispredict_cnt  output  16  number of mispredictions since reset.
REQ-018 err  output  1  sticky protocol error flag.

Function
REQ-019 The block SHALL hold a circular FIFO of {pc, npc_pred} entries with a head pointer, a tail pointer and a count; pointers SHALL wrap modulo DEPTH.
REQ-020 A push in state RUN with (count<DEPTH or an accepted resolve in the same cycle) SHALL write the entry at the tail; a push when full without an accepted resolve SHALL be dropped and SHALL set err.
REQ-021 A resolve with count>0 SHALL compare resolve_npc with the head's npc_pred over all 16 bits; a mismatch is a misprediction.
REQ-022 A resolve with count==0, or any resolve in state RECOVER, SHALL be ignored and SHALL set err.
REQ-023 On a correct resolve the block SHALL pop the head and leave btb_we and redirect low in the next cycle.
REQ-024 On a misprediction at edge N the block SHALL, in cycle N+1, drive btb_we=1 with btb_pc=head pc and btb_npc=resolve_npc, and redirect=1 with redirect_pc=resolve_npc.
REQ-025 Each strobe of REQ-024 SHALL be high for exactly one cycle.
REQ-026 A misprediction SHALL clear the whole queue (count=0, head=tail) at edge N, discarding all younger entries, and SHALL drop any push presented in the same cycle.
REQ-027 FSM states: RUN and RECOVER; RUN->RECOVER on misprediction; RECOVER->RUN unconditionally after one cycle.
REQ-028 In RECOVER, pushes SHALL be dropped without setting err, because they are wrong-path fetches.
REQ-029 mispredict_cnt SHALL increment by 1 per misprediction and saturate at 0xFFFF.
REQ-030 Simultaneous accepted push and correct resolve SHALL leave count unchanged and advance both pointers.

Reset
REQ-031 While rst=0: count=0, head=tail=0, state=RUN, btb_we=0, btb_pc=0, btb_npc=0, redirect=0, redirect_pc=0, mispredict_cnt=0, err=0; consequently full=0 and empty=1.
REQ-032 Assertion of rst in mid-operation SHALL immediately discard all entries and any pending strobe; queue storage contents need no reset.

Verification
REQ-033 Push (0x0100,0x0104), then resolve 0x0104 -> no btb_we, no redirect, count 1->0, mispredict_cnt=0.
REQ-034 Push (0x0200,0x0204), (0x0204,0x0208); resolve 0x0300 -> next cycle btb_we=1, btb_pc=0x0200, btb_npc=0x0300, redirect_pc=0x0300, count=0, mispredict_cnt=1; a push in the redirect cycle is dropped and err stays 0.
REQ-035 DEPTH=4: four pushes -> full=1; a fifth push alone is dropped, err=1; push plus correct resolve in the same cycle -> count stays 4 and the FIFO order is preserved across wrap.
REQ-036 Resolve when empty -> err=1, no strobes, count stays 0.
REQ-037 Three entries in flight with rst pulsed low mid-cycle -> outputs immediately take their reset values; after release, the first push/resolve pair behaves as REQ-033.
